// File: rtl/wb_pkg.sv
// Shared types for the Wishbone arbiter slice.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN_I,
        OWN_D
    } wb_grant_t;

    localparam int WB_NUM_MASTERS = 2;

    function automatic wb_grant_t wb_other(wb_grant_t g);
        return (g == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/wishbone.sv
// Wishbone classic bus bundle.
interface wishbone #(
    parameter int XLEN = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [XLEN/8-1:0] sel;
    logic [XLEN-1:0]   adr;
    logic [XLEN-1:0]   dat_w;
    logic [XLEN-1:0]   dat_r;
    logic              ack;
    logic              err;

    modport MASTER (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport SLAVE (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_watchdog.sv
// Per-transfer watchdog; fires on the TIMEOUT-th unanswered strobed cycle.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done,
    output logic expired
);
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    // cnt holds the number of earlier strobed cycles in this run
    assign expired = active && !done && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || done || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone arbiter, grant held per cyc,
// with a watchdog turning a hung slave into err.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input logic    clk,
    input logic    rst_n,
    wishbone.SLAVE  instr_m,
    wishbone.SLAVE  data_m,
    wishbone.MASTER mem_s
);
    localparam int SELW = XLEN / 8;

    wb_grant_t state;
    wb_grant_t state_nxt;
    wb_grant_t last_grant;

    logic            own_i;
    logic            own_d;
    logic            expired;
    logic            owner_stb;
    logic            slave_done;
    logic            cyc_m;
    logic            stb_m;
    logic            we_m;
    logic [SELW-1:0] sel_m;
    logic [XLEN-1:0] adr_m;
    logic [XLEN-1:0] dat_m;

    assign own_i = (state == OWN_I);
    assign own_d = (state == OWN_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= OWN_D;
        end else begin
            state <= state_nxt;
            if (state_nxt != IDLE && state_nxt != state) begin
                last_grant <= state_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (instr_m.cyc && data_m.cyc) begin
                    state_nxt = wb_other(last_grant);
                end else if (instr_m.cyc) begin
                    state_nxt = OWN_I;
                end else if (data_m.cyc) begin
                    state_nxt = OWN_D;
                end
            end
            OWN_I: begin
                if (!instr_m.cyc) begin
                    state_nxt = data_m.cyc ? OWN_D : IDLE;
                end
            end
            OWN_D: begin
                if (!data_m.cyc) begin
                    state_nxt = instr_m.cyc ? OWN_I : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cyc_m = 1'b0;
        stb_m = 1'b0;
        we_m  = 1'b0;
        sel_m = '0;
        adr_m = '0;
        dat_m = '0;
        unique case (1'b1)
            own_i: begin
                cyc_m = instr_m.cyc;
                stb_m = instr_m.stb;
                we_m  = instr_m.we;
                sel_m = instr_m.sel;
                adr_m = instr_m.adr;
                dat_m = instr_m.dat_w;
            end
            own_d: begin
                cyc_m = data_m.cyc;
                stb_m = data_m.stb;
                we_m  = data_m.we;
                sel_m = data_m.sel;
                adr_m = data_m.adr;
                dat_m = data_m.dat_w;
            end
            default: ;
        endcase
    end

    assign owner_stb  = stb_m;
    assign slave_done = mem_s.ack || mem_s.err;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (owner_stb),
        .done    (slave_done),
        .expired (expired)
    );

    assign mem_s.cyc   = cyc_m;
    assign mem_s.stb   = stb_m && !expired;
    assign mem_s.we    = we_m;
    assign mem_s.sel   = sel_m;
    assign mem_s.adr   = adr_m;
    assign mem_s.dat_w = dat_m;

    assign instr_m.dat_r = mem_s.dat_r;
    assign data_m.dat_r  = mem_s.dat_r;
    assign instr_m.ack   = own_i && mem_s.ack;
    assign data_m.ack    = own_d && mem_s.ack;
    assign instr_m.err   = own_i && (mem_s.err || expired);
    assign data_m.err    = own_d && (mem_s.err || expired);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with TIMEOUT=8.
module tb_wb_arbiter;
    logic clk;
    logic rst_n;

    wishbone #(.XLEN(32)) ibus ();
    wishbone #(.XLEN(32)) dbus ();
    wishbone #(.XLEN(32)) mbus ();

    int n_vec;
    int n_err;

    wb_arbiter #(
        .XLEN    (32),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .instr_m (ibus),
        .data_m  (dbus),
        .mem_s   (mbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ibus.cyc = 0; ibus.stb = 0; ibus.we = 0;
        ibus.sel = '0; ibus.adr = '0; ibus.dat_w = '0;
        dbus.cyc = 0; dbus.stb = 0; dbus.we = 0;
        dbus.sel = '0; dbus.adr = '0; dbus.dat_w = '0;
        mbus.ack = 0; mbus.err = 0; mbus.dat_r = '0;

        // reset values
        mid();
        chk("rst_cyc", 32'(mbus.cyc), 0);
        chk("rst_stb", 32'(mbus.stb), 0);
        chk("rst_we", 32'(mbus.we), 0);
        chk("rst_sel", 32'(mbus.sel), 0);
        chk("rst_adr", mbus.adr, 0);
        chk("rst_datw", mbus.dat_w, 0);
        chk("rst_iack", 32'({ibus.ack, ibus.err}), 0);
        chk("rst_dack", 32'({dbus.ack, dbus.err}), 0);
        nxt();
        rst_n = 1'b1;

        // single instr read
        ibus.cyc = 1; ibus.stb = 1; ibus.sel = 4'hF; ibus.adr = 32'h40;
        mid();
        chk("rd_c0_stb", 32'(mbus.stb), 0);
        nxt();
        mid();
        chk("rd_c1_stb", 32'(mbus.stb), 1);
        chk("rd_c1_adr", mbus.adr, 32'h40);
        chk("rd_c1_sel", 32'(mbus.sel), 32'hF);
        nxt();
        mbus.ack = 1; mbus.dat_r = 32'hDEADBEEF;
        mid();
        chk("rd_iack", 32'(ibus.ack), 1);
        chk("rd_idat", ibus.dat_r, 32'hDEADBEEF);
        chk("rd_dack", 32'(dbus.ack), 0);
        chk("rd_ddat", dbus.dat_r, 32'hDEADBEEF);
        nxt();
        mbus.ack = 0;
        ibus.cyc = 0; ibus.stb = 0;
        mid();
        chk("rd_drop_cyc", 32'(mbus.cyc), 0);
        nxt();

        // tie after reset: instr first, then direct hand-over
        pulse_reset();
        nxt();
        ibus.cyc = 1; ibus.stb = 1; ibus.adr = 32'h80;
        dbus.cyc = 1; dbus.stb = 1; dbus.adr = 32'h200;
        mid();
        chk("tie_c0_cyc", 32'(mbus.cyc), 0);
        nxt();
        mid();
        chk("tie_c1_adr", mbus.adr, 32'h80);
        nxt();
        mid();
        chk("tie_c2_adr", mbus.adr, 32'h80);
        nxt();
        ibus.cyc = 0; ibus.stb = 0;
        mid();
        chk("tie_c3_cyc", 32'(mbus.cyc), 0);
        nxt();
        mid();
        chk("tie_c4_cyc", 32'(mbus.cyc), 1);
        chk("tie_c4_adr", mbus.adr, 32'h200);
        nxt();
        dbus.cyc = 0; dbus.stb = 0;
        nxt();
        ibus.cyc = 1; ibus.stb = 1;
        dbus.cyc = 1; dbus.stb = 1;
        nxt();
        mid();
        chk("tie2_adr", mbus.adr, 32'h80);
        nxt();
        ibus.cyc = 0; ibus.stb = 0;
        dbus.cyc = 0; dbus.stb = 0;
        nxt();
        nxt();

        // held grant: data does 4 writes while instr waits
        dbus.cyc = 1; dbus.stb = 1; dbus.we = 1; dbus.sel = 4'hF;
        dbus.adr = 32'h100; dbus.dat_w = 32'h11;
        nxt();
        ibus.cyc = 1; ibus.stb = 1; ibus.adr = 32'h84;
        mbus.ack = 1;
        for (int k = 0; k < 4; k++) begin
            dbus.adr = 32'h100 + 32'(4 * k);
            dbus.dat_w = 32'h11 + 32'(k);
            mid();
            chk("hold_adr", mbus.adr, 32'h100 + 32'(4 * k));
            chk("hold_datw", mbus.dat_w, 32'h11 + 32'(k));
            chk("hold_we", 32'(mbus.we), 1);
            chk("hold_dack", 32'(dbus.ack), 1);
            chk("hold_iack", 32'(ibus.ack), 0);
            nxt();
        end
        mbus.ack = 0;
        dbus.cyc = 0; dbus.stb = 0; dbus.we = 0;
        mid();
        chk("hold_gap_cyc", 32'(mbus.cyc), 0);
        nxt();
        mid();
        chk("hold_igrant", mbus.adr, 32'h84);
        chk("hold_iwe", 32'(mbus.we), 0);
        nxt();
        ibus.cyc = 0; ibus.stb = 0;
        nxt();
        nxt();

        // timeout then ack on the 8th cycle
        dbus.cyc = 1; dbus.stb = 1; dbus.adr = 32'h500;
        nxt();
        for (int k = 1; k <= 8; k++) begin
            mid();
            if (k < 8) begin
                chk("to_err_lo", 32'(dbus.err), 0);
                chk("to_stb_hi", 32'(mbus.stb), 1);
            end else begin
                chk("to_err_hi", 32'(dbus.err), 1);
                chk("to_stb_lo", 32'(mbus.stb), 0);
                chk("to_cyc_hi", 32'(mbus.cyc), 1);
                chk("to_ierr", 32'(ibus.err), 0);
            end
            nxt();
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) mbus.ack = 1;
            mid();
            if (k < 8) begin
                chk("to2_err_lo", 32'(dbus.err), 0);
            end else begin
                chk("to2_ack", 32'(dbus.ack), 1);
                chk("to2_noerr", 32'(dbus.err), 0);
                chk("to2_stb", 32'(mbus.stb), 1);
            end
            nxt();
        end
        mbus.ack = 0;
        mid();
        chk("to3_restart", 32'(dbus.err), 0);
        nxt();

        // reset mid-transfer while data owns
        mbus.ack = 1;
        mid();
        chk("mr_dack", 32'(dbus.ack), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_cyc", 32'(mbus.cyc), 0);
        chk("mr_stb", 32'(mbus.stb), 0);
        chk("mr_adr", mbus.adr, 0);
        chk("mr_dack0", 32'({dbus.ack, dbus.err}), 0);
        ibus.cyc = 1; ibus.stb = 1; ibus.adr = 32'h80;
        nxt();
        rst_n = 1'b1;
        mbus.ack = 0;
        mid();
        chk("mr_idle", 32'(mbus.cyc), 0);
        nxt();
        mid();
        chk("mr_tie", mbus.adr, 32'h80);
        nxt();
        ibus.cyc = 0; ibus.stb = 0;
        dbus.cyc = 0; dbus.stb = 0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master to one-slave Wishbone classic arbiter sitting directly downstream of the RV32IC core. It merges the core's `instr_bus` and `data_bus` master ports onto a single shared memory/peripheral bus. Arbitration is round-robin, and each grant is held for a whole `cyc` transaction. A per-transfer watchdog turns a hung slave into a Wishbone error instead of a permanent pipeline stall.

## Interface
Parameters:
- `XLEN`, 32, address/data width; select width is XLEN/8.
- `TIMEOUT`, 255, maximum cycles a strobed transfer may wait for `ack`/`err` before the arbiter aborts it; legal range 1..65535.

Ports:
- `clk` input 1: single clock; all state on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr_m` `wishbone.SLAVE` (master 0): connects to core `instr_bus`.
- `data_m` `wishbone.SLAVE` (master 1): connects to core `data_bus`.
- `mem_s` `wishbone.MASTER`: the shared downstream bus.

Each interface carries:
- `cyc`, `stb`, `we`
- `sel[XLEN/8-1:0]`, `adr[XLEN-1:0]`
- `dat_w[XLEN-1:0]`, `dat_r[XLEN-1:0]`
- `ack`, `err`

## Operation
- **FSM states:** `IDLE`, `OWN_I`, `OWN_D`, held in a registered grant register.
- **Request:** master `k` requests when `cyc` is high.
- **IDLE:**
  - Exactly one requester: move to that master's `OWN` state.
  - Both requesting: grant the master *not* recorded in `last_grant`.
- **OWN_x:**
  - Stay while owner `cyc` is high.
  - When owner `cyc` is low: go to `OWN` of the other master if it is requesting, else `IDLE`. This is a direct switch with no dead cycle.
  - On every grant, `last_grant` records the new owner.
- **Forwarding:**
  - Owner's `cyc`/`stb`/`we`/`sel`/`adr`/`dat_w` are muxed combinationally to `mem_s`.
  - In `IDLE`, all `mem_s` outputs are 0.
- **Responses:**
  - `mem_s.dat_r` is broadcast to both masters.
  - `ack`/`err` go only to the owner; the non-owner always sees `ack`=`err`=0.
- **Watchdog:**
  - Counter clears whenever the FSM is not in an `OWN` state, owner `stb` is low, or `mem_s` `ack`/`err` is high.
  - Otherwise the counter increments, saturating at TIMEOUT.
  - When count==TIMEOUT: assert `err` to the owner for exactly that cycle and force `mem_s.stb`=0 that cycle. The counter then clears.
  - Owner `cyc` is untouched; the master decides whether to drop it.
- **Simultaneous slave `ack` and timeout:** `ack` wins; no `err` is generated.
- **Reset (any time, including mid-transfer):**
  - FSM to `IDLE`, `last_grant`=`OWN_D` (so instr wins the first tie), counter=0.
  - All `mem_s` outputs and both masters' `ack`/`err` go 0 immediately (asynchronous).
  - An in-flight transfer is dropped silently.

## Timing
- **Arbitration latency:** 1 cycle. A request raised in cycle n with the FSM in `IDLE` appears on `mem_s` in cycle n+1.
- **Hand-over:** owner drops `cyc` in cycle n while the other master is requesting → the other master owns `mem_s` in cycle n+1. `mem_s.cyc` is low in cycle n.
- **Response path:** `ack`/`err`/`dat_r` from slave to owner are combinational (0 cycles), so a single-cycle slave keeps 1 transfer/cycle within a held grant.
- **Timeout:** `err` is asserted in the TIMEOUT-th consecutive cycle of `stb` high without a response, counting the first strobed cycle as 1.
- **Reset values:** `mem_s.cyc`/`stb`/`we`=0; `sel`/`adr`/`dat_w`=0; `instr_m.ack`/`err`=0; `data_m.ack`/`err`=0.
- No combinational path from master request inputs to grant; the grant changes only on `clk`/`rst_n`.

## Structure
- Package `wb_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} wb_grant_t`
  - `localparam int WB_NUM_MASTERS = 2`
- Sub-module `wb_watchdog` (params `TIMEOUT`; ports `clk`, `rst_n`, `active`, `done`, `expired`) holds the saturating counter.
- Top level holds the FSM, `last_grant`, and the combinational muxes.

## Test plan
- **Single instr read:** instr `cyc`/`stb` at cycle 0, slave acks at cycle 2 with `dat_r`=0xDEADBEEF. → `mem_s.stb` first high at cycle 1; `instr_m.ack` at cycle 2 with data; `data_m.ack` stays 0.
- **Tie after reset:** both masters request in cycle 0. → instr granted cycle 1. instr drops `cyc` cycle 3. → data owns cycle 4 with no idle cycle. Next tie → instr again.
- **Held grant:** data holds `cyc` for 4 back-to-back writes (`adr` 0x100..0x10C) with 1-cycle slave acks while instr requests. → instr waits; instr is granted only in the cycle after data `cyc` falls.
- **Timeout:** TIMEOUT=8, slave never responds. → owner `err` high in the 8th strobed cycle, `mem_s.stb`=0 that cycle. Repeat with `ack` on cycle 8. → `ack` passed through, no `err`.
- **Reset mid-transfer:** assert `rst_n`=0 asynchronously while data owns the bus. → all `mem_s` outputs 0 before the next edge. After release → FSM `IDLE`, instr wins the next tie.
